// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: drives the req/ack data bus, stalls while an
// access is outstanding, and registers the MEM/WB fields for writeback.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic [1:0]  ResultSrcW,
  output logic        RegWriteW,
  output logic [1:0]  ExcW
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] cnt;
  logic       is_mem, aligned, acc, misalign, is_load, complete, abort;

  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = 8'(rdata >> {off, 3'b000});
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'h000000, b};
      3'b101:  res = {16'h0000, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  always_comb begin
    is_mem = MemReadM | MemWriteM;
    case (Funct3M[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ALUResultM[0];
      default: aligned = (ALUResultM[1:0] == 2'b00);
    endcase
    acc      = is_mem & aligned;
    misalign = is_mem & ~aligned;
    is_load  = MemReadM & ~MemWriteM;
  end

  // Bus outputs are combinational; the M inputs are frozen while stalled.
  always_comb begin
    if (reset) begin
      mem_req = 1'b0;
    end else if (state == S_WAIT) begin
      mem_req = 1'b1;
    end else begin
      mem_req = acc;
    end
    mem_we    = mem_req & MemWriteM;
    mem_addr  = {ALUResultM[31:2], 2'b00};
    mem_be    = 4'b1111;
    mem_wdata = WriteDataM;
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00: begin
          mem_wdata = {4{WriteDataM[7:0]}};
          mem_be    = 4'b0001 << ALUResultM[1:0];
        end
        2'b01: begin
          mem_wdata = {2{WriteDataM[15:0]}};
          mem_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          mem_wdata = WriteDataM;
          mem_be    = 4'b1111;
        end
      endcase
    end else begin
      mem_be = 4'b1111;
    end
    StallM   = mem_req & ~mem_ack;
    complete = mem_req & mem_ack;
    abort    = ~reset & (state == S_WAIT) & ~mem_ack & (cnt == TIMEOUT_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      PCPlus4W   <= 32'd0;
      RdW        <= 5'd0;
      ResultSrcW <= 2'b00;
      RegWriteW  <= 1'b0;
      ExcW       <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (acc && !mem_ack) begin
            state <= S_WAIT;
            cnt   <= 8'd1;
          end else begin
            state <= S_IDLE;
            cnt   <= 8'd0;
          end
        end
        S_WAIT: begin
          if (mem_ack || abort) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 8'd0;
        end
      endcase

      // A stalled cycle inserts a bubble; the abort cycle instead retires with an error.
      if (StallM && !abort) begin
        RdW       <= 5'd0;
        RegWriteW <= 1'b0;
        ExcW      <= 2'b00;
      end else begin
        ALUResultW <= ALUResultM;
        PCPlus4W   <= PCPlus4M;
        RdW        <= RdM;
        ResultSrcW <= ResultSrcM;
        RegWriteW  <= RegWriteM & ~misalign & ~abort;
        ExcW       <= misalign ? 2'b01 : (abort ? 2'b10 : 2'b00);
        ReadDataW  <= (complete && is_load) ? load_extract(mem_rdata, ALUResultM[1:0], Funct3M)
                                            : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// accesses checked against a size/offset arithmetic model.
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, mem_rdata;
  logic [4:0]  RdM;
  logic        RegWriteM, MemReadM, MemWriteM, mem_ack;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic        StallM, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic [1:0]  ResultSrcW, ExcW;
  logic        RegWriteW;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .Funct3M(Funct3M), .StallM(StallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW), .ExcW(ExcW)
  );

  always #5 clk = ~clk;

  task automatic set_nop();
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    RegWriteM = 1'b0;
    mem_ack   = 1'b0;
  endtask

  // One full access: drives the M inputs, acks after 'delay' cycles, checks every cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int delay, output int stalls);
    int size, exp_stalls, ncyc, bm;
    logic mem_op, acc, mis, ab, is_load, exp_rw;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rdw;
    logic [1:0]  exp_exc;
    longint v;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr;
    WriteDataM = wd; mem_rdata = rdata;
    RdM = 5'($urandom); PCPlus4M = $urandom; ResultSrcM = 2'($urandom);
    RegWriteM = 1'($urandom);
    size   = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    mem_op = rd | wr;
    acc    = mem_op && ((addr % size) == 0);
    mis    = mem_op && !acc;
    exp_stalls = acc ? ((delay < TO + 1) ? delay : TO + 1) : 0;
    ab     = acc && (delay >= TO + 1);
    ncyc   = ab ? exp_stalls : exp_stalls + 1;
    bm     = ((1 << size) - 1) << (addr % 4);
    exp_be = wr ? 4'(bm) : 4'hF;
    exp_wd = (size == 1) ? 32'(wd[7:0]) * 32'h01010101 :
             (size == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
    v = longint'(rdata >> (8 * (addr % 4)));
    if (size < 4) begin
      v = v & ((longint'(1) << (8 * size)) - 1);
      if (!f3[2] && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
    end
    is_load = rd && !wr;
    exp_rdw = (is_load && acc && !ab) ? 32'(v) : 32'd0;
    exp_rw  = RegWriteM && !mis && !ab;
    exp_exc = mis ? 2'b01 : (ab ? 2'b10 : 2'b00);
    stalls  = 0;
    for (int c = 0; c < ncyc; c++) begin
      mem_ack = (c == delay);
      #1;
      checks++;
      if (mem_req !== acc)
        $display("FAIL mem_req cyc%0d: got %b want %b", c, mem_req, acc);
      if (mem_req !== acc) errors++;
      if (acc) begin
        checks++;
        if ({mem_we, mem_addr, mem_be} !== {wr, addr & 32'hFFFF_FFFC, exp_be}) begin
          errors++;
          $display("FAIL bus_ctl: got we=%b addr=%h be=%b want we=%b addr=%h be=%b",
                   mem_we, mem_addr, mem_be, wr, addr & 32'hFFFF_FFFC, exp_be);
        end
        if (wr) begin
          checks++;
          if (mem_wdata !== exp_wd) begin
            errors++;
            $display("FAIL wdata: got %h want %h", mem_wdata, exp_wd);
          end
        end
      end
      checks++;
      if (StallM !== (c < exp_stalls)) begin
        errors++;
        $display("FAIL stall cyc%0d: got %b want %b", c, StallM, (c < exp_stalls));
      end
      if (StallM === 1'b1) stalls++;
      @(posedge clk); #1;
      if (c < ncyc - 1) begin
        checks++;
        if ({RdW, RegWriteW, ExcW} !== 8'd0) begin
          errors++;
          $display("FAIL bubble: got rd=%0d rw=%b exc=%b want 0", RdW, RegWriteW, ExcW);
        end
      end
    end
    checks++;
    if ({ALUResultW, PCPlus4W, RdW, ResultSrcW, RegWriteW, ExcW} !==
        {addr, PCPlus4M, RdM, ResultSrcM, exp_rw, exp_exc}) begin
      errors++;
      $display("FAIL wb_fields: got alu=%h pc4=%h rd=%0d rs=%b rw=%b exc=%b want %h %h %0d %b %b %b",
               ALUResultW, PCPlus4W, RdW, ResultSrcW, RegWriteW, ExcW,
               addr, PCPlus4M, RdM, ResultSrcM, exp_rw, exp_exc);
    end
    checks++;
    if (ReadDataW !== exp_rdw) begin
      errors++;
      $display("FAIL read_data: got %h want %h", ReadDataW, exp_rdw);
    end
    set_nop();
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: got %b want 0", mem_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    MemReadM = 1'b1; MemWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h100;
    WriteDataM = 32'h0; RdM = 5'd3; PCPlus4M = 32'h4; RegWriteM = 1'b1;
    ResultSrcM = 2'b01; mem_rdata = 32'h0; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({mem_req, mem_we, StallM} !== 3'b000) begin
      errors++;
      $display("FAIL reset_bus: got req=%b we=%b stall=%b want 000", mem_req, mem_we, StallM);
    end
    checks++;
    if ({ALUResultW, ReadDataW, PCPlus4W, RdW, ResultSrcW, RegWriteW, ExcW} !== 106'd0) begin
      errors++;
      $display("FAIL reset_wb: got alu=%h rd=%h pc=%h want all 0", ALUResultW, ReadDataW, PCPlus4W);
    end
    set_nop();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_lw_immediate();
    int st;
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, st);
    checks++;
    if (st !== 0) begin
      errors++;
      $display("FAIL lw_imm_stalls: got %0d want 0", st);
    end
  endtask

  task automatic test_byte_load_stall();
    int st;
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 3, st);
    checks++;
    if (st !== 3 || ReadDataW !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL lb_stall: got stalls=%0d data=%h want 3 ffffff80", st, ReadDataW);
    end
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 3, st);
    checks++;
    if (ReadDataW !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu: got %h want 00000080", ReadDataW);
    end
  endtask

  task automatic test_store_half();
    int st;
    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, st);
  endtask

  task automatic test_misaligned();
    int st;
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, st);
    checks++;
    if (ExcW !== 2'b01 || RegWriteW !== 1'b0) begin
      errors++;
      $display("FAIL misalign: got exc=%b rw=%b want 01 0", ExcW, RegWriteW);
    end
  endtask

  task automatic test_timeout();
    int st;
    run_access(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 100, st);
    checks++;
    if (st !== 5 || ExcW !== 2'b10 || RegWriteW !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got stalls=%0d exc=%b rw=%b want 5 10 0", st, ExcW, RegWriteW);
    end
  endtask

  task automatic test_reset_mid_access();
    int st;
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h400;
    RegWriteM = 1'b1; RdM = 5'd9; mem_ack = 1'b0;
    #1;
    @(posedge clk); #1;
    checks++;
    if (StallM !== 1'b1) begin
      errors++;
      $display("FAIL wait_stall: got %b want 1", StallM);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, StallM} !== 2'b00) begin
      errors++;
      $display("FAIL rst_wait_bus: got req=%b stall=%b want 00", mem_req, StallM);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_nop();
    #1;
    checks++;
    if ({mem_req, StallM, ALUResultW, ReadDataW, PCPlus4W, RdW, ResultSrcW, RegWriteW, ExcW} !== 108'd0) begin
      errors++;
      $display("FAIL rst_wait_after: got req=%b stall=%b rd=%0d rw=%b want all 0",
               mem_req, StallM, RdW, RegWriteW);
    end
    run_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0BADF00D, 0, st);
  endtask

  task automatic test_random();
    int st;
    for (int i = 0; i < 60; i++) begin
      run_access(1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 $urandom_range(0, 6), st);
    end
  endtask

  initial begin
    test_reset();
    test_lw_immediate();
    test_byte_load_stall();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
